// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pad; resets to the idle-high line level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // their inputs from the same clock edge; blocking here would collapse the pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable oversampling UART receiver (data width, parity, stop bits).
// Define UART_RX_MAJORITY_EN for 2-of-3 majority voting on every bit decision.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = PARITY_NONE,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_tick,
  input  logic                 rx,
  output logic                 rx_done,
  output logic [DATA_BITS-1:0] d_out,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic          ODD_PAR   = (PARITY_MODE == PARITY_ODD);

  rx_state_t            state;
  logic [TW-1:0]        tick_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 perr;
  logic                 ferr;
  logic                 rx_s;
  logic                 rx_prev;
  logic                 bit_val;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // hist holds rx_s from the two previous ticks, so at sample count S the vote
  // covers counts S-2, S-1 and S without changing the decision point.
  logic [1:0] hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      hist <= 2'b11;
    else if (s_tick) hist <= {hist[0], rx_s};
  end

  assign bit_val = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  assign bit_val = rx_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      rx_prev    <= 1'b1;
      rx_done    <= 1'b0;
      d_out      <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      rx_prev <= rx_s;
      case (state)
        IDLE: begin
          // Falling edge only: a line stuck low after a break never restarts.
          if (rx_prev && !rx_s) begin
            state    <= START;
            tick_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        START: begin
          if (s_tick) begin
            if (tick_cnt == HALF_LAST) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              if (!bit_val) begin
                state <= DATA;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt <= '0;
              shift    <= {bit_val, shift[DATA_BITS-1:1]};
              if (bit_cnt == DATA_LAST) begin
                bit_cnt <= '0;
                perr    <= 1'b0;
                ferr    <= 1'b0;
                state   <= (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (s_tick) begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt <= '0;
              perr     <= ((^shift) ^ bit_val) != ODD_PAR;
              state    <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt <= '0;
              if (!bit_val) ferr <= 1'b1;
              if (bit_cnt == STOP_LAST) begin
                bit_cnt    <= '0;
                d_out      <= shift;
                parity_err <= perr;
                frame_err  <= ferr | ~bit_val;
                rx_done    <= 1'b1;
                busy       <= 1'b0;
                state      <= IDLE;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        // NOTE: the default arm recovers from an illegal encoding; every
        // register already holds its value when not assigned, so no latch risk.
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
